si_frame_rx: RTL

- Serial-link receiver for the S1→S2 upload path.
- Samples the shared sen/sd link, deserializes each address+data frame MSB-first, and writes the data word into an RB2-style register bank through its single-port write interface.
- Counts completed frames and raises done after the configured frame count, like S2_done.
- Sits directly downstream of the transmitter that drives sen/sd.

---
 rtl/si_frame_rx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/si_frame_rx.sv
// Serial frame receiver: deserializes address+data frames from the sen/sd link
// and writes each into a register bank. Optional macro: SI_RX_SEQ_CHECK_EN.
module si_frame_rx #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 18,
  parameter int NUM_FRAMES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sen,
  input  logic              sd,
  output logic              rb_rw,
  output logic [ADDR_W-1:0] rb_a,
  output logic [DATA_W-1:0] rb_d,
  output logic              done,
  output logic              frame_abort
`ifdef SI_RX_SEQ_CHECK_EN
  ,
  output logic              seq_err
`endif
);

  localparam int L    = ADDR_W + DATA_W;
  localparam int BC_W = $clog2(L + 1);
  localparam int FC_W = $clog2(NUM_FRAMES + 1);
  localparam logic [BC_W-1:0] LAST_BIT   = BC_W'(L - 1);
  localparam logic [FC_W-1:0] FRAMES_MAX = FC_W'(NUM_FRAMES);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;

  state_t            state_q, state_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [L-1:0]      shift_q, shift_d;
  logic              rb_rw_q, rb_rw_d;
  logic [ADDR_W-1:0] rb_a_q, rb_a_d;
  logic [DATA_W-1:0] rb_d_q, rb_d_d;
  logic              done_q, done_d;
  logic              frame_abort_q, frame_abort_d;
  logic [L-1:0]      shift_next;
  logic              accept;
`ifdef SI_RX_SEQ_CHECK_EN
  logic              seq_err_q, seq_err_d;
`endif

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    frame_cnt_d   = frame_cnt_q;
    shift_d       = shift_q;
    rb_rw_d       = 1'b1;
    rb_a_d        = rb_a_q;
    rb_d_d        = rb_d_q;
    done_d        = done_q;
    frame_abort_d = 1'b0;
`ifdef SI_RX_SEQ_CHECK_EN
    seq_err_d     = seq_err_q;
`endif
    shift_next = {shift_q[L-2:0], sd};
`ifdef SI_RX_SEQ_CHECK_EN
    // A frame is only accepted when its address names the next expected slot.
    accept = ({{ADDR_W{1'b0}}, frame_cnt_q} == {{FC_W{1'b0}}, shift_next[L-1:DATA_W]});
`else
    accept = 1'b1;
`endif

    // Done is raised one edge after the final write, from whatever state holds then.
    if (state_q != DONE && frame_cnt_q == FRAMES_MAX) begin
      state_d = DONE;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (en && !sen) begin
            shift_d  = {{(L-1){1'b0}}, sd};
            bitcnt_d = BC_W'(1);
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (!en || sen) begin
            frame_abort_d = 1'b1;
            bitcnt_d      = '0;
            state_d       = IDLE;
          end else begin
            shift_d  = shift_next;
            bitcnt_d = bitcnt_q + BC_W'(1);
            if (bitcnt_q == LAST_BIT) begin
              state_d = HOLD;
              if (accept) begin
                rb_rw_d     = 1'b0;
                rb_a_d      = shift_next[L-1:DATA_W];
                rb_d_d      = shift_next[DATA_W-1:0];
                frame_cnt_d = frame_cnt_q + FC_W'(1);
              end
`ifdef SI_RX_SEQ_CHECK_EN
              else begin
                seq_err_d = 1'b1;
              end
`endif
            end
          end
        end
        HOLD: begin
          if (sen) begin
            state_d = IDLE;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      bitcnt_q      <= '0;
      frame_cnt_q   <= '0;
      shift_q       <= '0;
      rb_rw_q       <= 1'b1;
      rb_a_q        <= '0;
      rb_d_q        <= '0;
      done_q        <= 1'b0;
      frame_abort_q <= 1'b0;
`ifdef SI_RX_SEQ_CHECK_EN
      seq_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      frame_cnt_q   <= frame_cnt_d;
      shift_q       <= shift_d;
      rb_rw_q       <= rb_rw_d;
      rb_a_q        <= rb_a_d;
      rb_d_q        <= rb_d_d;
      done_q        <= done_d;
      frame_abort_q <= frame_abort_d;
`ifdef SI_RX_SEQ_CHECK_EN
      seq_err_q     <= seq_err_d;
`endif
    end
  end

  assign rb_rw       = rb_rw_q;
  assign rb_a        = rb_a_q;
  assign rb_d        = rb_d_q;
  assign done        = done_q;
  assign frame_abort = frame_abort_q;
`ifdef SI_RX_SEQ_CHECK_EN
  assign seq_err     = seq_err_q;
`endif

endmodule
